// File: rtl/led_blink_driver.sv
// led_blink_driver
//    Turns a one-cycle trigger strobe into a timed blink pattern on an LED pin:
//    blink_num blinks, each ON_TICKS cycles lit followed by OFF_TICKS cycles
//    dark. busy is high while the pattern plays. done strobes for one cycle
//    when the last off period ends.
//
//    Optional feature macro: LED_BLINK_RETRIGGER_EN
//       defined   : a valid trigger while busy restarts the pattern with the
//                   new blink_num (no done for the aborted pattern)
//       undefined : triggers while busy are ignored
//
// Ports
//    CLK        in   system clock (5 MHz), rising edge
//    RST        in   synchronous active-low reset
//    trigger    in   event strobe
//    blink_num  in   [3:0] blinks requested (0 = ignore trigger)
//    led        out  LED pin, registered; LED_ACTIVE means lit
//    busy       out  pattern in progress, registered
//    done       out  one-cycle completion strobe, registered
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no pattern; waiting for a trigger
// ON    | LED lit; cnt counts up to ON_TICKS-1
// OFF   | LED dark; cnt counts up to OFF_TICKS-1; rem blinks still to go

module led_blink_driver #(
   parameter int unsigned ON_TICKS   = 500000,
   parameter int unsigned OFF_TICKS  = 500000,
   parameter int unsigned CNT_W      = 20,
   parameter logic        LED_ACTIVE = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       trigger,
   input  logic [3:0] blink_num,
   output logic       led,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       rem, rem_nxt;
   logic             led_nxt, busy_nxt, done_nxt;
   logic             start_ok;

   assign start_ok = trigger && (blink_num != 4'd0);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         rem   <= 4'd0;
         led   <= ~LED_ACTIVE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rem   <= rem_nxt;
         led   <= led_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rem_nxt   = rem;
      done_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start_ok) begin
               rem_nxt   = blink_num;
               cnt_nxt   = '0;
               state_nxt = S_ON;
            end
         end

         S_ON: begin
`ifdef LED_BLINK_RETRIGGER_EN
            if (start_ok) begin
               rem_nxt   = blink_num;
               cnt_nxt   = '0;
               state_nxt = S_ON;
            end else
`endif
            if (cnt == ON_LAST) begin
               cnt_nxt   = '0;
               rem_nxt   = rem - 4'd1;
               state_nxt = S_OFF;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_OFF: begin
`ifdef LED_BLINK_RETRIGGER_EN
            // A restart also wins over the final off-period expiry, so an
            // aborted pattern never reports done.
            if (start_ok) begin
               rem_nxt   = blink_num;
               cnt_nxt   = '0;
               state_nxt = S_ON;
            end else
`endif
            if (cnt == OFF_LAST) begin
               cnt_nxt = '0;
               if (rem != 4'd0) begin
                  state_nxt = S_ON;
               end else begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            rem_nxt   = 4'd0;
         end
      endcase

      // Outputs are registered from the next state so they change on the
      // same edge as the transition.
      led_nxt  = (state_nxt == S_ON) ? LED_ACTIVE : ~LED_ACTIVE;
      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_led_blink_driver.sv
module tb_led_blink_driver;

   localparam int ON  = 4;
   localparam int OFF = 3;
   localparam int PER = ON + OFF;
`ifdef LED_BLINK_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       trigger = 1'b0;
   logic [3:0] blink_num = 4'd0;
   logic       led, busy, done;

   int compared   = 0;
   int mismatched = 0;

   led_blink_driver #(
      .ON_TICKS  (ON),
      .OFF_TICKS (OFF),
      .CNT_W     (4),
      .LED_ACTIVE(1'b1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .trigger  (trigger),
      .blink_num(blink_num),
      .led      (led),
      .busy     (busy),
      .done     (done)
   );

   always #100 CLK = ~CLK;

   // Reference model: a pattern is (start edge, N). Outputs follow from the
   // elapsed edge count with plain arithmetic.
   int   cyc = 0;
   bit   m_active = 1'b0;
   int   m_start = 0;
   int   m_n = 0;
   logic exp_led = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

   always @(posedge CLK) begin
      bit ending, accept;
      cyc++;
      exp_done = 1'b0;
      if (!RST) begin
         m_active = 1'b0;
      end else begin
         ending = m_active && ((cyc - m_start) == m_n * PER);
         accept = trigger && (blink_num != 4'd0) && (!m_active || RETRIG);
         if (accept) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_n      = int'(blink_num);
         end else if (ending) begin
            m_active = 1'b0;
            exp_done = 1'b1;
         end
      end
      exp_busy = m_active;
      exp_led  = m_active && (((cyc - m_start) % PER) < ON);
   end

   task automatic test_reset();
      RST = 1'b0; trigger = 1'b1; blink_num = 4'd3;
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1;
         compared++;
         if ({led, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_hold edge %0d: got led/busy/done=%b want 000", i, {led, busy, done});
         end
      end
      RST = 1'b1; trigger = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK); #1;
         compared++;
         if ({led, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_release cycle %0d: got %b want 000", i, {led, busy, done});
         end
      end
   endtask

   task automatic test_single_blink();
      logic [2:0] e;
      trigger = 1'b1; blink_num = 4'd1;
      for (int j = 0; j < 10; j++) begin
         @(posedge CLK); #1;
         if (j == 0) begin trigger = 1'b0; blink_num = 4'($urandom_range(0, 15)); end
         e = {1'(j < 4), 1'(j < 7), 1'(j == 7)};
         compared++;
         if ({led, busy, done} !== e) begin
            mismatched++;
            $display("FAIL single_blink k+%0d: got led/busy/done=%b want %b", j, {led, busy, done}, e);
         end
      end
   endtask

   task automatic test_three_blinks();
      int rises = 0, busy_cyc = 0, dones = 0;
      logic prev_led = 1'b0;
      trigger = 1'b1; blink_num = 4'd3;
      for (int j = 0; j < 28; j++) begin
         @(posedge CLK); #1;
         if (j == 0) trigger = 1'b0;
         if (led && !prev_led) rises++;
         prev_led = led;
         if (busy) busy_cyc++;
         if (done) dones++;
         compared++;
         if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
            mismatched++;
            $display("FAIL three_model k+%0d: got %b want %b", j, {led, busy, done}, {exp_led, exp_busy, exp_done});
         end
      end
      compared++;
      if (rises !== 3) begin mismatched++; $display("FAIL three_rises: got %0d want 3", rises); end
      compared++;
      if (busy_cyc !== 21) begin mismatched++; $display("FAIL three_busy: got %0d want 21", busy_cyc); end
      compared++;
      if (dones !== 1) begin mismatched++; $display("FAIL three_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_zero_count();
      trigger = 1'b1; blink_num = 4'd0;
      for (int j = 0; j < 10; j++) begin
         @(posedge CLK); #1;
         trigger = 1'b0;
         compared++;
         if ({led, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL zero_count k+%0d: got %b want 000", j, {led, busy, done});
         end
      end
   endtask

   task automatic test_busy_trigger();
      int first_done = -1, dones = 0;
      int want_done = RETRIG ? 40 : 14;
      trigger = 1'b1; blink_num = 4'd2;
      for (int j = 0; j < 48; j++) begin
         @(posedge CLK); #1;
         trigger = 1'b0;
         if (j == 4) begin trigger = 1'b1; blink_num = 4'd5; end
         if (done) begin
            dones++;
            if (first_done < 0) first_done = j;
         end
         if (j == 5) begin
            compared++;
            if (led !== RETRIG) begin
               mismatched++;
               $display("FAIL busy_trig_led_k+5: got %b want %b", led, RETRIG);
            end
         end
         compared++;
         if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
            mismatched++;
            $display("FAIL busy_trig_model k+%0d: got %b want %b", j, {led, busy, done}, {exp_led, exp_busy, exp_done});
         end
      end
      compared++;
      if (first_done !== want_done) begin
         mismatched++;
         $display("FAIL busy_trig_done_edge: got k+%0d want k+%0d", first_done, want_done);
      end
      compared++;
      if (dones !== 1) begin mismatched++; $display("FAIL busy_trig_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_mid_reset();
      int dones = 0, busy_cyc = 0, done_at = -1;
      trigger = 1'b1; blink_num = 4'd3;
      for (int j = 0; j < 30; j++) begin
         @(posedge CLK); #1;
         trigger = 1'b0;
         if (j == 1) RST = 1'b0;
         if (j == 2) begin
            RST = 1'b1;
            compared++;
            if ({led, busy} !== 2'b00) begin
               mismatched++;
               $display("FAIL mid_reset_k+2: got led/busy=%b want 00", {led, busy});
            end
         end
         if (done) dones++;
      end
      compared++;
      if (dones !== 0) begin mismatched++; $display("FAIL mid_reset_no_done: got %0d want 0", dones); end
      trigger = 1'b1; blink_num = 4'd3;
      for (int j = 0; j < 26; j++) begin
         @(posedge CLK); #1;
         trigger = 1'b0;
         if (busy) busy_cyc++;
         if (done && done_at < 0) done_at = j;
      end
      compared++;
      if (busy_cyc !== 21 || done_at !== 21) begin
         mismatched++;
         $display("FAIL mid_reset_rerun: got busy=%0d done_at=%0d want 21/21", busy_cyc, done_at);
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 1500; j++) begin
         @(posedge CLK); #1;
         compared++;
         if ({led, busy, done} !== {exp_led, exp_busy, exp_done}) begin
            mismatched++;
            $display("FAIL random cyc %0d: got %b want %b", cyc, {led, busy, done}, {exp_led, exp_busy, exp_done});
         end
         trigger   = ($urandom_range(0, 7) == 0);
         blink_num = 4'($urandom_range(0, 4));
         RST       = ($urandom_range(0, 249) != 0);
      end
      RST = 1'b1; trigger = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_blink();
      test_three_blinks();
      test_zero_count();
      test_busy_trigger();
      repeat (4) @(posedge CLK);
      #1;
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
